// File: rtl/ising_spin_core.sv
// ising_spin_core: annealing core for a small Ising machine.
// N spins with a programmable signed coupling matrix J (diagonal entries act
// as per-spin bias). Each sweep visits the spins in order. For each spin the
// core accumulates its local field over N cycles. It then adds LFSR noise
// scaled by the current temperature and takes the sign as the new spin.
// The temperature decays by temp_step (saturating at 0) after every sweep.
// Optional feature macro: ISING_FLIP_CNT_EN adds o_flips, which gives the
// number of spins that changed during the most recent complete sweep.
module ising_spin_core #(
  parameter int          N_SPINS   = 4,
  parameter int          W_BITS    = 4,
  parameter int          T_BITS    = 4,
  parameter int          S_BITS    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cfg_we,
  input  logic [$clog2(N_SPINS)-1:0]  i_cfg_row,
  input  logic [$clog2(N_SPINS)-1:0]  i_cfg_col,
  input  logic signed [W_BITS-1:0]    i_cfg_data,
  input  logic                        i_start,
  input  logic [S_BITS-1:0]           i_sweeps,
  input  logic [T_BITS-1:0]           i_temp_init,
  input  logic [T_BITS-1:0]           i_temp_step,
  input  logic [N_SPINS-1:0]          i_spin_init,
  output logic [N_SPINS-1:0]          o_spins,
  output logic [T_BITS-1:0]           o_temp,
  output logic                        o_busy,
  output logic                        o_done
`ifdef ISING_FLIP_CNT_EN
  ,
  output logic [$clog2(N_SPINS):0]    o_flips
`endif
);

  localparam int IW = $clog2(N_SPINS);
  // The local field is wide enough for N terms of |J| <= 2^(W_BITS-1), so it never wraps.
  localparam int FW = W_BITS + IW + 1;
  // The noise*temp product is kept at full width before the arithmetic shift.
  localparam int PW = FW + T_BITS + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SPINS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic signed [W_BITS-1:0]  r_jMat [N_SPINS][N_SPINS];
  logic [IW-1:0]             r_row;
  logic [IW-1:0]             r_col;
  logic signed [FW-1:0]      r_acc;
  logic [N_SPINS-1:0]        r_spins;
  logic [T_BITS-1:0]         r_temp;
  logic [T_BITS-1:0]         r_tempStep;
  logic [S_BITS-1:0]         r_sweepCnt;
  logic [15:0]               r_lfsr;
  logic                      r_busy;
  logic                      r_done;

  logic signed [W_BITS-1:0]  w_jRaw;
  logic signed [FW-1:0]      w_jExt;
  logic signed [FW-1:0]      w_term;
  logic signed [PW-1:0]      w_noiseExt;
  logic signed [PW-1:0]      w_tempExt;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW-1:0]      w_scaled;
  logic signed [PW-1:0]      w_accExt;
  logic signed [PW-1:0]      w_sum;
  logic                      w_newSpin;
  logic [15:0]               w_lfsrNext;
  logic [T_BITS-1:0]         w_tempNext;
  logic                      w_sweepEnd;
  logic                      w_startAccept;

  // The coupling term is +J when s_j = +1 and -J when s_j = -1. The diagonal (bias) entry always enters as +J.
  assign w_jRaw = r_jMat[r_row][r_col];
  assign w_jExt = {{(FW-W_BITS){w_jRaw[W_BITS-1]}}, w_jRaw};
  assign w_term = ((r_row == r_col) || r_spins[r_col]) ? w_jExt : -w_jExt;

  // The low FW bits of the LFSR are the signed noise. The temperature scales it as a fraction of 2^T_BITS.
  assign w_noiseExt = {{(PW-FW){r_lfsr[FW-1]}}, r_lfsr[FW-1:0]};
  assign w_tempExt  = {{(PW-T_BITS){1'b0}}, r_temp};
  assign w_prod     = w_noiseExt * w_tempExt;
  assign w_scaled   = w_prod >>> T_BITS;
  assign w_accExt   = {{(PW-FW){r_acc[FW-1]}}, r_acc};
  assign w_sum      = w_accExt + w_scaled;
  assign w_newSpin  = ~w_sum[PW-1];

  // Galois LFSR for x^16+x^14+x^13+x^11+1, shifting right.
  assign w_lfsrNext = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  assign w_tempNext    = (r_temp > r_tempStep) ? (r_temp - r_tempStep) : '0;
  assign w_sweepEnd    = (r_state == S_DECIDE) && (r_row == LAST_IDX);
  assign w_startAccept = (r_state == S_IDLE) && i_start;

  // Main control FSM and datapath: configuration, field accumulation, spin decision and sweep bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      for (int a = 0; a < N_SPINS; a++) begin
        for (int b = 0; b < N_SPINS; b++) begin
          r_jMat[a][b] <= '0;
        end
      end
      r_row      <= '0;
      r_col      <= '0;
      r_acc      <= '0;
      r_spins    <= '0;
      r_temp     <= '0;
      r_tempStep <= '0;
      r_sweepCnt <= '0;
      r_lfsr     <= LFSR_SEED;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_cfg_we) begin
            r_jMat[i_cfg_row][i_cfg_col] <= i_cfg_data;
          end
          if (i_start) begin
            r_spins    <= i_spin_init;
            r_temp     <= i_temp_init;
            r_tempStep <= i_temp_step;
            r_sweepCnt <= i_sweeps;
            r_row      <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            if (i_sweeps != '0) begin
              r_state <= S_ACCUM;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_term;
          if (r_col == LAST_IDX) begin
            r_state <= S_DECIDE;
          end else begin
            r_col <= r_col + IW'(1);
          end
        end
        S_DECIDE: begin
          r_spins[r_row] <= w_newSpin;
          r_lfsr         <= w_lfsrNext;
          r_col          <= '0;
          r_acc          <= '0;
          if (r_row != LAST_IDX) begin
            r_row   <= r_row + IW'(1);
            r_state <= S_ACCUM;
          end else begin
            r_row      <= '0;
            r_temp     <= w_tempNext;
            r_sweepCnt <= r_sweepCnt - S_BITS'(1);
            if (r_sweepCnt == S_BITS'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_spins = r_spins;
  assign o_temp  = r_temp;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

`ifdef ISING_FLIP_CNT_EN
  logic          w_flip;
  logic [IW:0]   r_flipAcc;
  logic [IW:0]   r_flips;

  assign w_flip = (w_newSpin != r_spins[r_row]);

  // Count the spin changes within a sweep and publish the total when the sweep ends.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flipAcc <= '0;
      r_flips   <= '0;
    end else if (w_startAccept) begin
      r_flipAcc <= '0;
      r_flips   <= '0;
    end else if (w_sweepEnd) begin
      r_flips   <= r_flipAcc + (IW+1)'(w_flip);
      r_flipAcc <= '0;
    end else if (r_state == S_DECIDE) begin
      r_flipAcc <= r_flipAcc + (IW+1)'(w_flip);
    end
  end

  assign o_flips = r_flips;
`else
  logic w_unusedCtl;
  assign w_unusedCtl = w_sweepEnd ^ w_startAccept;
`endif

endmodule
